// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// alu_pkg : opcodes and FSM state encoding shared by seq_alu and its datapath
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_CAT = 2'b10;
    localparam logic [1:0] OP_SHL = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

`default_nettype wire

// File: rtl/seq_mul_unit.sv
//------------------------------------------------------------------------------
// seq_mul_unit : W-cycle shift-add multiplier, one partial product per clock
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_mul_unit #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           done,
    output logic [2*W-1:0] product
);

    logic            r_run;
    logic [CW-1:0]   r_cnt;
    logic [2*W-1:0]  r_mcand;
    logic [W-1:0]    r_mplier;
    logic [2*W-1:0]  r_acc;
    logic [2*W-1:0]  w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // product is the accumulator after the current iteration, so the FSM can
    // latch the finished result on the very edge that performs iteration W.
    assign done    = r_run && (r_cnt == CW'(W - 1));
    assign product = w_acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (start) begin
            r_run    <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= {{W{1'b0}}, A};
            r_mplier <= B;
            r_acc    <= '0;
        end else if (r_run) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
//------------------------------------------------------------------------------
// seq_alu : clocked add/mul/concat/shift ALU with valid/ready on both sides
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_alu
    import alu_pkg::*;
#(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic [1:0]     S,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [2*W-1:0] Y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy
);

    logic [1:0]     r_state;
    logic [2*W-1:0] r_y;
    logic           w_accept;
    logic           w_mul_start;
    logic           w_mul_done;
    logic [2*W-1:0] w_mul_product;
    logic [2*W-1:0] w_result;

    // HOLD accepts only when the consumer drains the current result this cycle.
    assign in_ready = rst_n && ((r_state == ST_IDLE) ||
                                ((r_state == ST_HOLD) && out_ready));
    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && (S == OP_MUL);

    assign Y         = r_y;
    assign out_valid = (r_state == ST_HOLD);
    assign busy      = (r_state == ST_MUL);

    always_comb begin
        w_result = '0;
        case (S)
            OP_ADD:  w_result = {{W{1'b0}}, A} + {{W{1'b0}}, B};
            OP_CAT:  w_result = {A, B};
            OP_SHL:  w_result = {{W{1'b0}}, A} << B;
            default: w_result = '0;
        endcase
    end

    seq_mul_unit #(
        .W  (W),
        .CW (CW)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .A       (A),
        .B       (B),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_y     <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HOLD: begin
                    if (w_accept) begin
                        if (S == OP_MUL) begin
                            r_state <= ST_MUL;
                        end else begin
                            r_state <= ST_HOLD;
                            r_y     <= w_result;
                        end
                    end else if ((r_state == ST_HOLD) && out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_state <= ST_HOLD;
                        r_y     <= w_mul_product;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
//------------------------------------------------------------------------------
// tb_seq_alu : scoreboard bench for seq_alu, directed cases plus random traffic
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_alu;

    localparam int W  = 4;
    localparam int RW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [1:0]    S;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] Y;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    seq_alu #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .S         (S),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: unsigned arithmetic on wide integers, truncated to 2W.
    function automatic logic [63:0] model(input int unsigned a, input int unsigned b,
                                          input logic [1:0] s);
        longint unsigned mask = (64'd1 << RW) - 1;
        case (s)
            2'b00:   return a + b;
            2'b01:   return longint'(a) * longint'(b);
            2'b10:   return longint'(a) * (64'd1 << W) + b;
            default: return (b >= RW) ? 64'd0 : ((longint'(a) << b) & mask);
        endcase
    endfunction

    // Monitor: every handshake on the output side retires one expected result.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: Y=%0h with no result pending at %0t", Y, $time);
            end else begin
                check("result", Y, exp_q.pop_front());
            end
        end
    end

    // Present an operation, wait for acceptance, and score it if a result is due.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s,
                         input bit expect_it, input bit rand_ready);
        bit ok = 1'b0;
        A = a;
        B = b;
        S = s;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
            end
        end
        check("accept_in_time", {63'd0, ok}, 64'd1);
        if (ok) begin
            @(posedge clk);
            if (expect_it) exp_q.push_back(model(a, b, s));
            #1;
        end
        in_valid = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        S = 2'($urandom);
    endtask

    task automatic drain();
        bit done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && out_valid === 1'b0) done = 1'b1;
        end
        check("drain_in_time", {63'd0, done}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        A         = 4'h5;
        B         = 4'h3;
        S         = 2'b00;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_y", Y, 64'd0);
        check("reset_out_valid", out_valid, 64'd0);
        check("reset_in_ready", in_ready, 64'd0);
        check("reset_busy", busy, 64'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 64'd1);
        @(posedge clk);
        #1;

        // Single-cycle ops: result visible right after the accept edge.
        issue(4'd9, 4'd7, 2'b00, 1'b1, 1'b0);
        check("add_latency", out_valid, 64'd1);
        check("add_value", Y, 64'h10);
        issue(4'hA, 4'h5, 2'b10, 1'b1, 1'b0);
        check("cat_value", Y, 64'hA5);
        issue(4'd3, 4'd2, 2'b11, 1'b1, 1'b0);
        check("shl_value", Y, 64'h0C);
        issue(4'd3, 4'd9, 2'b11, 1'b1, 1'b0);
        check("shl_overrange", Y, 64'h00);
        drain();

        // Multiply 15x15: busy for exactly W cycles, result after edge k+W.
        issue(4'd15, 4'd15, 2'b01, 1'b1, 1'b0);
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            check("mul_busy", busy, 64'd1);
            check("mul_in_ready", in_ready, 64'd0);
            check("mul_out_valid_low", out_valid, 64'd0);
        end
        @(negedge clk);
        check("mul_out_valid", out_valid, 64'd1);
        check("mul_busy_done", busy, 64'd0);
        check("mul_value", Y, 64'hE1);
        @(posedge clk);
        #1;
        issue(4'd0, 4'd13, 2'b01, 1'b1, 1'b0);
        drain();

        // Back-pressure: result and flags frozen while the consumer stalls.
        out_ready = 1'b0;
        issue(4'd9, 4'd7, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_y", Y, 64'h10);
            check("hold_out_valid", out_valid, 64'd1);
            check("hold_in_ready", in_ready, 64'd0);
            A = W'($urandom);
            B = W'($urandom);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(4'hA, 4'h5, 2'b10, 1'b1, 1'b0);
        check("bp_next_valid", out_valid, 64'd1);
        check("bp_next_value", Y, 64'hA5);
        drain();

        // Back-to-back stream, in-order results.
        issue(4'd6, 4'd8, 2'b00, 1'b1, 1'b0);
        issue(4'h3, 4'hC, 2'b10, 1'b1, 1'b0);
        issue(4'd11, 4'd13, 2'b01, 1'b1, 1'b0);
        drain();

        // Reset during iteration 2 of a multiply must abort it without a result.
        issue(4'd15, 4'd15, 2'b01, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 64'd0);
        check("abort_out_valid", out_valid, 64'd0);
        check("abort_in_ready", in_ready, 64'd0);
        rst_n = 1'b1;
        repeat (2 * W + 4) @(negedge clk);
        check("abort_no_result", out_valid, 64'd0);
        check("abort_y", Y, 64'd0);
        @(posedge clk);
        #1;

        // Random traffic with a randomly stalling consumer.
        for (int n = 0; n < 80; n++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            issue(W'($urandom), W'($urandom), 2'($urandom), 1'b1, 1'b1);
        end
        drain();

        check("queue_empty", exp_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
